// File: rtl/rgb2ycbcr_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2ycbcr_pipe
//  Purpose  : 7-stage RGB -> Y / YCbCr converter with frame-latched coefficients.
//  Revision : 1.0  initial release
// ============================================================================
module rgb2ycbcr_pipe #(
   parameter int DATA_W  = 8,
   parameter int COEF_W  = 18,
   parameter int FRAC_W  = 17,
   parameter int KR_RST  = 39191,
   parameter int KB_RST  = 14942,
   parameter int KCB_RST = 73925,
   parameter int KCR_RST = 93454
) (
   input  logic                     clk,
   input  logic                     rst_n_i,
   input  logic signed [COEF_W-1:0] kr_i,
   input  logic signed [COEF_W-1:0] kb_i,
   input  logic signed [COEF_W-1:0] kcb_i,
   input  logic signed [COEF_W-1:0] kcr_i,
   input  logic                     mode_i,
   input  logic                     dv_i,
   input  logic                     hs_i,
   input  logic                     vs_i,
   input  logic [DATA_W-1:0]        r_i,
   input  logic [DATA_W-1:0]        g_i,
   input  logic [DATA_W-1:0]        b_i,
   output logic                     dv_o,
   output logic                     hs_o,
   output logic                     vs_o,
   output logic [DATA_W-1:0]        y_o,
   output logic [DATA_W-1:0]        cb_o,
   output logic [DATA_W-1:0]        cr_o
);

   localparam int c_pw  = COEF_W + DATA_W + 1;
   localparam int c_sw  = c_pw + 2;
   localparam int c_lat = 7;
   localparam logic signed [c_sw-1:0] c_round      = c_sw'(1) << (FRAC_W - 1);
   localparam logic signed [c_sw-1:0] c_chroma_off = (c_sw'(1) << (DATA_W - 1 + FRAC_W)) + c_round;

   function automatic logic [DATA_W-1:0] f_sat(input logic signed [c_sw-1:0] x);
      if (x[c_sw-1])
         return '0;
      else if (|x[c_sw-2:DATA_W])
         return '1;
      else
         return x[DATA_W-1:0];
   endfunction

   // Frame-shadowed parameters; the capture-cycle pixel bypasses to the new values.
   logic                     r_vs_prev;
   logic signed [COEF_W-1:0] r_kr_sh, r_kb_sh, r_kcb_sh, r_kcr_sh;
   logic                     r_mode_sh;
   logic                     w_vs_rise;
   logic signed [COEF_W-1:0] w_kr, w_kb, w_kcb, w_kcr;
   logic                     w_mode;

   assign w_vs_rise = vs_i & ~r_vs_prev;
   assign w_kr      = w_vs_rise ? kr_i   : r_kr_sh;
   assign w_kb      = w_vs_rise ? kb_i   : r_kb_sh;
   assign w_kcb     = w_vs_rise ? kcb_i  : r_kcb_sh;
   assign w_kcr     = w_vs_rise ? kcr_i  : r_kcr_sh;
   assign w_mode    = w_vs_rise ? mode_i : r_mode_sh;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_vs_prev <= 1'b0;
         r_kr_sh   <= COEF_W'(KR_RST);
         r_kb_sh   <= COEF_W'(KB_RST);
         r_kcb_sh  <= COEF_W'(KCB_RST);
         r_kcr_sh  <= COEF_W'(KCR_RST);
         r_mode_sh <= 1'b0;
      end else begin
         r_vs_prev <= vs_i;
         if (w_vs_rise) begin
            r_kr_sh   <= kr_i;
            r_kb_sh   <= kb_i;
            r_kcb_sh  <= kcb_i;
            r_kcr_sh  <= kcr_i;
            r_mode_sh <= mode_i;
         end
      end
   end

   logic signed [DATA_W:0]   r_rg1, r_bg1;
   logic [DATA_W-1:0]        r_r1, r_g1, r_b1, r_r2, r_g2, r_b2, r_r3, r_b3;
   logic signed [COEF_W-1:0] r_kr1, r_kb1;
   logic signed [COEF_W-1:0] r_kcb1, r_kcr1, r_kcb2, r_kcr2, r_kcb3, r_kcr3, r_kcb4, r_kcr4;
   logic                     r_mode1, r_mode2, r_mode3, r_mode4, r_mode5, r_mode6;
   logic signed [c_pw-1:0]   r_pr2, r_pb2, r_pcb5, r_pcr5;
   logic signed [c_sw-1:0]   r_ysum3, r_cbsum6, r_crsum6;
   logic [DATA_W-1:0]        r_y4, r_y5, r_y6, r_y7, r_cb7, r_cr7;
   logic signed [DATA_W:0]   r_bmy4, r_rmy4;
   logic [3*c_lat-1:0]       r_ctl_sr;
   logic signed [c_sw-1:0]   w_gsh2;
   logic [DATA_W-1:0]        w_ysat3;

   assign w_gsh2  = c_sw'($signed({1'b0, r_g2})) <<< FRAC_W;
   assign w_ysat3 = f_sat(r_ysum3 >>> FRAC_W);

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rg1 <= '0;  r_bg1 <= '0;
         r_r1 <= '0;   r_g1 <= '0;   r_b1 <= '0;
         r_r2 <= '0;   r_g2 <= '0;   r_b2 <= '0;
         r_r3 <= '0;   r_b3 <= '0;
         r_kr1 <= '0;  r_kb1 <= '0;
         r_kcb1 <= '0; r_kcr1 <= '0; r_kcb2 <= '0; r_kcr2 <= '0;
         r_kcb3 <= '0; r_kcr3 <= '0; r_kcb4 <= '0; r_kcr4 <= '0;
         r_mode1 <= 1'b0; r_mode2 <= 1'b0; r_mode3 <= 1'b0;
         r_mode4 <= 1'b0; r_mode5 <= 1'b0; r_mode6 <= 1'b0;
         r_pr2 <= '0;  r_pb2 <= '0;  r_pcb5 <= '0; r_pcr5 <= '0;
         r_ysum3 <= '0; r_cbsum6 <= '0; r_crsum6 <= '0;
         r_y4 <= '0;   r_y5 <= '0;   r_y6 <= '0;   r_y7 <= '0;
         r_cb7 <= '0;  r_cr7 <= '0;
         r_bmy4 <= '0; r_rmy4 <= '0;
         r_ctl_sr <= '0;
      end else begin
         // S1
         r_rg1   <= $signed({1'b0, r_i}) - $signed({1'b0, g_i});
         r_bg1   <= $signed({1'b0, b_i}) - $signed({1'b0, g_i});
         r_r1    <= r_i;   r_g1 <= g_i;   r_b1 <= b_i;
         r_kr1   <= w_kr;  r_kb1 <= w_kb; r_kcb1 <= w_kcb; r_kcr1 <= w_kcr;
         r_mode1 <= w_mode;
         // S2
         r_pr2   <= c_pw'(r_kr1) * c_pw'(r_rg1);
         r_pb2   <= c_pw'(r_kb1) * c_pw'(r_bg1);
         r_r2    <= r_r1;  r_g2 <= r_g1;  r_b2 <= r_b1;
         r_kcb2  <= r_kcb1; r_kcr2 <= r_kcr1; r_mode2 <= r_mode1;
         // S3
         r_ysum3 <= c_sw'(r_pr2) + c_sw'(r_pb2) + w_gsh2 + c_round;
         r_r3    <= r_r2;  r_b3 <= r_b2;
         r_kcb3  <= r_kcb2; r_kcr3 <= r_kcr2; r_mode3 <= r_mode2;
         // S4: chroma differences use the saturated luma
         r_y4    <= w_ysat3;
         r_bmy4  <= $signed({1'b0, r_b3}) - $signed({1'b0, w_ysat3});
         r_rmy4  <= $signed({1'b0, r_r3}) - $signed({1'b0, w_ysat3});
         r_kcb4  <= r_kcb3; r_kcr4 <= r_kcr3; r_mode4 <= r_mode3;
         // S5
         r_pcb5  <= c_pw'(r_kcb4) * c_pw'(r_bmy4);
         r_pcr5  <= c_pw'(r_kcr4) * c_pw'(r_rmy4);
         r_y5    <= r_y4;  r_mode5 <= r_mode4;
         // S6
         r_cbsum6 <= c_sw'(r_pcb5) + c_chroma_off;
         r_crsum6 <= c_sw'(r_pcr5) + c_chroma_off;
         r_y6     <= r_y5; r_mode6 <= r_mode5;
         // S7
         r_y7     <= r_y6;
         r_cb7    <= r_mode6 ? f_sat(r_cbsum6 >>> FRAC_W) : '0;
         r_cr7    <= r_mode6 ? f_sat(r_crsum6 >>> FRAC_W) : '0;
         r_ctl_sr <= {r_ctl_sr[3*c_lat-4:0], dv_i, hs_i, vs_i};
      end
   end

   assign dv_o = r_ctl_sr[3*c_lat-1];
   assign hs_o = r_ctl_sr[3*c_lat-2];
   assign vs_o = r_ctl_sr[3*c_lat-3];
   assign y_o  = r_y7;
   assign cb_o = r_cb7;
   assign cr_o = r_cr7;

endmodule
`default_nettype wire

// File: doc/rgb2ycbcr_pipe.md
Name: rgb2ycbcr_pipe

Overview:
- Parametrised successor to the single-channel luma converter.
- Converts one RGB pixel per clock into Y, or into Y plus Cb/Cr, selected per frame.
- Uses signed fixed-point coefficients, rounding and saturation.
- Sits between the video input timing path and the 2D FIR filter front-end.
- Delays dv/hs/vs so they stay aligned with the pixel data.

Parameters:
- DATA_W, 8: bits per colour component in and out.
- COEF_W, 18: signed coefficient width.
- FRAC_W, 17: fractional bits of every coefficient.
- KR_RST, 39191: Kr after reset (0.299).
- KB_RST, 14942: Kb after reset (0.114).
- KCB_RST, 73925: Kcb after reset (0.564).
- KCR_RST, 93454: Kcr after reset (0.713).

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- kr_i  in  COEF_W  signed Kr.
- kb_i  in  COEF_W  signed Kb.
- kcb_i  in  COEF_W  signed Kcb.
- kcr_i  in  COEF_W  signed Kcr.
- mode_i  in  1  0 = Y only, 1 = YCbCr.
- dv_i  in  1  data valid.
- hs_i  in  1  horizontal sync.
- vs_i  in  1  vertical sync.
- r_i  in  DATA_W  red component.
- g_i  in  DATA_W  green component.
- b_i  in  DATA_W  blue component.
- dv_o  out  1  delayed dv_i.
- hs_o  out  1  delayed hs_i.
- vs_o  out  1  delayed vs_i.
- y_o  out  DATA_W  luma.
- cb_o  out  DATA_W  blue chroma.
- cr_o  out  DATA_W  red chroma.

Behaviour:
- Reset: asynchronous, active-low. Clock is clk; reset is rst_n_i. While rst_n_i=0:
  - all pipeline and control registers clear to 0;
  - dv_o=hs_o=vs_o=0 and y_o=cb_o=cr_o=0;
  - shadow coefficients load the *_RST parameters;
  - shadow mode loads 0.
  Reset asserted mid-frame discards all in-flight pixels. No stale output appears after release.
- Shadow registers: coefficients and mode_i are captured on a vs_i rising edge (vs_i=1 and registered previous vs_i=0). They then stay constant for the whole frame. Changing the inputs mid-frame has no effect until the next vs_i rising edge. The pixel presented on the capture cycle already uses the new values.
- Arithmetic:
  - Y' = Kr*(R-G) + Kb*(B-G) + (G << FRAC_W) + 2^(FRAC_W-1).
  - Y = sat(Y' >>> FRAC_W).
  - Cb' = Kcb*(B_d - Y) + (2^(DATA_W-1) << FRAC_W) + 2^(FRAC_W-1).
  - Cr' = Kcr*(R_d - Y) + same offset.
  - Cb = sat(Cb' >>> FRAC_W); Cr = sat(Cr' >>> FRAC_W).
  - R_d and B_d are R and B delayed to align with the saturated Y.
  - Differences are signed DATA_W+1 bits. Products and sums are sized so no intermediate overflow is possible for any input or coefficient.
  - sat(): negative gives 0; greater than 2^DATA_W-1 gives 2^DATA_W-1; otherwise the low DATA_W bits.
- Pipeline: fixed latency of 7 clocks from the input sample to the outputs, in every mode.
  - S1: register inputs and form R-G, B-G.
  - S2: multiply.
  - S3: sum, offset and round.
  - S4: saturate Y; form B_d-Y and R_d-Y.
  - S5: multiply.
  - S6: sum, offset and round.
  - S7: saturate chroma; register the outputs.
  - Y is delay-matched through S5–S7.
- Control: {dv,hs,vs} go through a 7-deep shift register, so dv_o(t) = dv_i(t-7), and likewise for hs_o and vs_o.
- Mode: the shadow mode bit travels with each pixel. When it is 0, cb_o=cr_o=0 and y_o is computed as usual.
- dv_i=0: the datapath still computes (no gating); outputs follow the inputs with the same latency. Downstream qualifies with dv_o.
- Throughput: one pixel per clock with no stalls and no backpressure.

Test Plan:
- Reset defaults, mode=1, vs pulse, then R=G=B=128 with dv=1 → 7 clocks later y_o=128, cb_o=128, cr_o=128, dv_o=1.
- Default coefficients, R=255, G=0, B=0 → y_o=76, cb_o=85, cr_o=255 (upper saturation).
- Kr=-65536, Kb=0 latched at vs rise, R=255, G=0, B=0 → y_o=0 (negative saturation).
- mode_i changed 0→1 mid-frame → cb_o/cr_o stay 0 until the first pixel at or after the next vs_i rise. Same check for kr_i changed mid-frame: Y is unchanged until that vs rise.
- Random dv/hs/vs pattern → outputs equal the inputs delayed exactly 7 clocks. Assert rst_n_i low for 1 cycle mid-frame → all outputs 0 immediately; no pixels emerge for the 7 clocks after release unless new inputs arrive.
- Back-to-back pixels for 1000 cycles vs a bit-exact reference model → zero mismatches; also check at DATA_W=10.
